// File: rtl/rv32i_pkg.sv
// Shared RV32I core package: widths, debug run-control state and halt cause
// encodings.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int DBG_STEP_W = 8;

    typedef enum logic [1:0] {
        DBG_RUN     = 2'd0,
        DBG_HALTING = 2'd1,
        DBG_HALTED  = 2'd2,
        DBG_STEP    = 2'd3
    } dbg_state_e;

    typedef enum logic [2:0] {
        HC_NONE    = 3'd0,
        HC_HALTREQ = 3'd1,
        HC_BP0     = 3'd2,
        HC_BP1     = 3'd3,
        HC_STEP    = 3'd4
    } halt_cause_e;

endpackage

// File: rtl/rv32i_debug_ctrl.sv
// Debug run-control sequencer: breakpoint/halt/step/resume sequencing,
// issue stall generation and dpc / halt cause capture.
module rv32i_debug_ctrl #(
    parameter int                      XLEN          = rv32i_pkg::XLEN,
    parameter int                      STEP_W        = rv32i_pkg::DBG_STEP_W,
    parameter bit                      HALT_ON_RESET = 1'b0,
    parameter logic [XLEN-1:0]         RESET_PC      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    input  logic              instr_issue,
    input  logic              cpu_idle,
    input  logic              bp_hit,
    input  logic [1:0]        bp_index,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    output logic              cpu_stall,
    output logic              halted,
    output logic              resume_ack,
    output logic [2:0]        halt_cause,
    output logic [XLEN-1:0]   dpc
);

    import rv32i_pkg::*;

    dbg_state_e        state;
    dbg_state_e        state_nxt;
    halt_cause_e       cause;
    halt_cause_e       bp_cause;
    logic [STEP_W-1:0] cnt;
    logic              skip;
    logic              bp_eff;
    logic              cnt_zero;
    logic              issue_ok;

    assign bp_eff   = bp_hit & ~skip;
    assign cnt_zero = (cnt == '0);
    assign issue_ok = instr_issue & ~cpu_stall;
    assign bp_cause = (bp_index == 2'd0) ? HC_BP0 : HC_BP1;

    always_comb begin
        state_nxt = state;
        cpu_stall = 1'b1;
        unique case (state)
            DBG_RUN: begin
                cpu_stall = bp_eff;
                if (bp_eff || halt_req)
                    state_nxt = DBG_HALTING;
            end
            DBG_HALTING: begin
                if (cpu_idle)
                    state_nxt = DBG_HALTED;
            end
            DBG_HALTED: begin
                if (step_req)
                    state_nxt = DBG_STEP;
                else if (resume_req)
                    state_nxt = DBG_RUN;
            end
            DBG_STEP: begin
                cpu_stall = cnt_zero | bp_eff;
                if (cnt_zero || bp_eff || halt_req)
                    state_nxt = DBG_HALTING;
            end
            default: state_nxt = DBG_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HALT_ON_RESET ? DBG_HALTED : DBG_RUN;
            cause      <= HALT_ON_RESET ? HC_HALTREQ : HC_NONE;
            dpc        <= RESET_PC;
            cnt        <= '0;
            skip       <= 1'b0;
            resume_ack <= 1'b0;
        end else begin
            state      <= state_nxt;
            resume_ack <= 1'b0;
            if (issue_ok)
                skip <= 1'b0;
            unique case (state)
                DBG_RUN: begin
                    if (bp_eff) begin
                        dpc   <= pc;
                        cause <= bp_cause;
                    end else if (halt_req) begin
                        cause <= HC_HALTREQ;
                    end
                end
                DBG_HALTING: begin
                    // Breakpoint halts keep the pc captured at the hit.
                    if (cpu_idle && (cause == HC_HALTREQ || cause == HC_STEP))
                        dpc <= pc;
                end
                DBG_HALTED: begin
                    if (step_req) begin
                        cnt  <= (step_count == '0) ? STEP_W'(1) : step_count;
                        skip <= 1'b1;
                    end else if (resume_req) begin
                        skip       <= 1'b1;
                        resume_ack <= 1'b1;
                    end
                end
                DBG_STEP: begin
                    if (issue_ok)
                        cnt <= cnt - STEP_W'(1);
                    if (bp_eff) begin
                        dpc   <= pc;
                        cause <= bp_cause;
                    end else if (halt_req) begin
                        cause <= HC_HALTREQ;
                    end else if (cnt_zero) begin
                        cause <= HC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted     = (state == DBG_HALTED);
    assign halt_cause = cause;

endmodule

// File: tb/tb_rv32i_debug_ctrl.sv
// Directed bench for rv32i_debug_ctrl: breakpoint, skip, step, halt request,
// simultaneous events and reset, with a HALT_ON_RESET=1 twin for reset state.
module tb_rv32i_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        instr_issue;
    logic        cpu_idle;
    logic        bp_hit;
    logic [1:0]  bp_index;
    logic        halt_req;
    logic        resume_req;
    logic        step_req;
    logic [7:0]  step_count;

    logic        cpu_stall, halted, resume_ack;
    logic [2:0]  halt_cause;
    logic [31:0] dpc;
    logic        cpu_stall2, halted2, resume_ack2;
    logic [2:0]  halt_cause2;
    logic [31:0] dpc2;

    int n_checks = 0;
    int n_fail   = 0;
    int issued   = 0;
    int base;

    always #5 clk = ~clk;

    rv32i_debug_ctrl #(
        .XLEN(32), .STEP_W(8), .HALT_ON_RESET(1'b0), .RESET_PC(32'h0000_0040)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr_issue(instr_issue),
        .cpu_idle(cpu_idle), .bp_hit(bp_hit), .bp_index(bp_index),
        .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
        .step_count(step_count), .cpu_stall(cpu_stall), .halted(halted),
        .resume_ack(resume_ack), .halt_cause(halt_cause), .dpc(dpc)
    );

    rv32i_debug_ctrl #(
        .XLEN(32), .STEP_W(8), .HALT_ON_RESET(1'b1), .RESET_PC(32'h0000_0040)
    ) dut_hor (
        .clk(clk), .rst(rst), .pc(pc), .instr_issue(instr_issue),
        .cpu_idle(cpu_idle), .bp_hit(bp_hit), .bp_index(bp_index),
        .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
        .step_count(step_count), .cpu_stall(cpu_stall2), .halted(halted2),
        .resume_ack(resume_ack2), .halt_cause(halt_cause2), .dpc(dpc2)
    );

    always @(negedge clk)
        if (!rst && instr_issue && !cpu_stall)
            issued++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = '0; instr_issue = 0; cpu_idle = 0; bp_hit = 0;
        bp_index = 0; halt_req = 0; resume_req = 0; step_req = 0;
        step_count = 0;
        cyc(2);
        rst = 1'b0;
        #1;
        check("rst_halted", 32'(halted), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_cause", 32'(halt_cause), 0);
        check("rst_dpc", dpc, 32'h40);
        check("rst_ack", 32'(resume_ack), 0);
        check("hor_halted", 32'(halted2), 1);
        check("hor_cause", 32'(halt_cause2), 1);

        // Breakpoint BP1 at 0x100
        pc = 32'h100; instr_issue = 1; bp_hit = 1; bp_index = 1;
        #1 check("bp_stall_same", 32'(cpu_stall), 1);
        cyc();
        bp_hit = 0; cpu_idle = 1;
        #1 check("bp_halting", 32'(halted), 0);
        cyc();
        check("bp_halted", 32'(halted), 1);
        check("bp_dpc", dpc, 32'h100);
        check("bp_cause", 32'(halt_cause), 3);

        // Resume past own breakpoint, then re-hit
        base = issued;
        pc = 32'h100; bp_hit = 1; resume_req = 1;
        cyc();
        resume_req = 0;
        #1 check("res_ack", 32'(resume_ack), 1);
        check("res_skip_stall", 32'(cpu_stall), 0);
        cyc();
        check("res_ack_pulse", 32'(resume_ack), 0);
        pc = 32'h104; bp_hit = 0;
        cyc();
        pc = 32'h100; bp_hit = 1;
        #1 check("rehit_stall", 32'(cpu_stall), 1);
        cyc();
        bp_hit = 0;
        cyc();
        check("rehit_halted", 32'(halted), 1);
        check("res_issues", issued - base, 2);

        // Step of 3
        base = issued;
        pc = 32'h200; cpu_idle = 0; step_req = 1; step_count = 3;
        cyc();
        step_req = 0;
        cyc(5);
        check("step3_issues", issued - base, 3);
        check("step3_wait_idle", 32'(halted), 0);
        pc = 32'h20C; cpu_idle = 1;
        cyc();
        check("step3_halted", 32'(halted), 1);
        check("step3_cause", 32'(halt_cause), 4);
        check("step3_dpc", dpc, 32'h20C);

        // Step count 0 acts as 1
        base = issued;
        step_req = 1; step_count = 0;
        cyc();
        step_req = 0;
        cyc(3);
        check("step0_issues", issued - base, 1);
        check("step0_halted", 32'(halted), 1);

        // Step wins over resume; then reset mid-step with counter=2
        instr_issue = 0;
        step_req = 1; resume_req = 1; step_count = 2;
        cyc();
        step_req = 0; resume_req = 0;
        #1 check("sr_no_ack", 32'(resume_ack), 0);
        check("sr_step_stall", 32'(cpu_stall), 0);
        check("sr_not_halted", 32'(halted), 0);
        rst = 1;
        cyc();
        check("mrst_halted", 32'(halted), 0);
        check("mrst_stall", 32'(cpu_stall), 0);
        check("mrst_cause", 32'(halt_cause), 0);
        check("mrst_dpc", dpc, 32'h40);
        check("mrst_hor_halted", 32'(halted2), 1);
        rst = 0;
        base = issued;
        instr_issue = 1;
        cyc(5);
        check("mrst_run_issues", issued - base, 5);
        check("mrst_run", 32'(halted), 0);

        // Halt request with busy pipeline
        cpu_idle = 0; pc = 32'h2F0; halt_req = 1;
        #1 check("hreq_issue_ok", 32'(cpu_stall), 0);
        cyc();
        halt_req = 0;
        #1 check("hreq_stall", 32'(cpu_stall), 1);
        cyc(4);
        check("hreq_wait", 32'(halted), 0);
        pc = 32'h300; cpu_idle = 1;
        cyc();
        check("hreq_halted", 32'(halted), 1);
        check("hreq_cause", 32'(halt_cause), 1);
        check("hreq_dpc", dpc, 32'h300);

        // halt_req and BP0 in the same RUN cycle
        resume_req = 1;
        cyc();
        resume_req = 0;
        cyc();
        pc = 32'h400; halt_req = 1; bp_hit = 1; bp_index = 0;
        cyc();
        halt_req = 0; bp_hit = 0;
        cyc();
        check("both_halted", 32'(halted), 1);
        check("both_cause", 32'(halt_cause), 2);
        check("both_dpc", dpc, 32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_debug_ctrl.md
# rv32i_debug_ctrl

Debug run-control sequencer for the RV32I core. It consumes the breakpoint-hit indication from the breakpoint comparator and halt, resume and step commands from the APB debug slave. It drives the CPU issue stall and sequences the core through run, halt, single/multi-step and resume. It also captures the debug PC and halt cause for readback over APB.

## Interface
Parameters:
- XLEN, rv32i_pkg::XLEN (32): PC width
- STEP_W, 8: width of step count
- HALT_ON_RESET, 0: 1 = leave reset in HALTED state
- RESET_PC, 32'h0000_0000: dpc value loaded at reset

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  XLEN  PC of the instruction presented for issue this cycle
- instr_issue  in  1  CPU wants to issue the instruction at pc this cycle (accepted iff cpu_stall=0)
- cpu_idle  in  1  no instruction in flight in the pipeline
- bp_hit  in  1  breakpoint comparator match on pc (combinational)
- bp_index  in  2  which breakpoint matched (0=BP0, 1=BP1)
- halt_req  in  1  one-cycle halt command pulse
- resume_req  in  1  one-cycle resume command pulse
- step_req  in  1  one-cycle step command pulse
- step_count  in  STEP_W  instructions to execute per step_req; 0 treated as 1
- cpu_stall  out  1  block instruction issue (combinational)
- halted  out  1  core halted and drained (registered)
- resume_ack  out  1  one-cycle pulse on leaving HALTED via resume
- halt_cause  out  3  0=NONE, 1=HALTREQ, 2=BP0, 3=BP1, 4=STEP
- dpc  out  XLEN  PC of next instruction to execute when halted

## Operation
- States: RUN, HALTING, HALTED, STEP.
- Reset values: state=RUN, halted=0, halt_cause=NONE, dpc=RESET_PC, resume_ack=0, step counter=0, skip=0. If HALT_ON_RESET=1, state=HALTED, halted=1, halt_cause=HALTREQ.
- Effective hit: bp_eff = bp_hit & ~skip.
- skip is set when leaving HALTED, by resume or by step. It is cleared on the first accepted issue. The instruction at dpc therefore never re-triggers its own breakpoint.
- RUN:
  - cpu_stall = bp_eff.
  - On bp_eff: dpc<=pc, halt_cause<=BP0/BP1 per bp_index, next state HALTING.
  - Else on halt_req: halt_cause<=HALTREQ, next state HALTING.
  - bp_eff has priority over a simultaneous halt_req.
- HALTING:
  - cpu_stall=1.
  - When cpu_idle=1: go to HALTED.
  - For HALTREQ and STEP causes, dpc<=pc in the idle cycle. For BP causes, dpc keeps the captured value.
  - halt_req, resume_req and step_req are ignored.
- HALTED:
  - cpu_stall=1, halted=1.
  - step_req: load counter with max(step_count,1), set skip, go to STEP.
  - resume_req: set skip, pulse resume_ack, go to RUN.
  - step_req has priority over a simultaneous resume_req.
  - halt_req is ignored.
- STEP:
  - cpu_stall = (counter==0) | bp_eff.
  - Each accepted issue decrements the counter.
  - When counter reaches 0, or on bp_eff or halt_req, go to HALTING.
  - Cause priority: BP > HALTREQ > STEP.
- halt_cause holds its value until the next halt event; it is not cleared on resume.
- Counter is STEP_W bits and never wraps below 0.

## Timing
- Breakpoint halt:
  - Hit at cycle t: cpu_stall=1 in t, so the instruction at pc does not issue.
  - HALTING from t+1.
  - If cpu_idle=1 at t+1, HALTED at t+2 and halted=1 at t+2.
- halt_req at t: stall from t+1. Issue in cycle t is still allowed.
- resume_req at t in HALTED: RUN and resume_ack=1 at t+1; cpu_stall=0 from t+1.
- Step of N: exactly N issues accepted. cpu_stall is combinationally high in the cycle the counter is 0.
- Reset asserted in any state: next cycle takes reset values. Pending step count is discarded.

## Structure
- rv32i_pkg gets:
  - dbg_state_e (RUN, HALTING, HALTED, STEP)
  - halt_cause_e (NONE..STEP)
  - DBG_STEP_W default constant
- Single module. One always_ff holds state, counter, skip, dpc and cause; one always_comb computes next state and cpu_stall.
- No sub-module. The breakpoint comparator stays a separate instance wired at the top level.

## Test plan
- Breakpoint halt: bp_hit=1, bp_index=1 at pc=0x0000_0100; cpu_idle=1 next cycle -> stall same cycle, halted=1 two cycles later, dpc=0x100, halt_cause=3.
- Skip after resume: resume_req with pc=0x100 still matching BP -> resume_ack pulse, instruction at 0x100 issues, no re-halt. A later re-hit at 0x100 after a loop -> halts.
- Multi-step: step_req with step_count=3, instr_issue held high -> exactly 3 accepted issues, halted=1 after idle, halt_cause=4, dpc = pc at idle. step_count=0 -> exactly 1 issue.
- Halt request: halt_req in RUN with cpu_idle=0 for 4 cycles -> halted rises only after cpu_idle=1, halt_cause=1.
- Simultaneous events:
  - halt_req and bp_hit in the same RUN cycle -> cause=BP.
  - step_req and resume_req in the same HALTED cycle -> STEP taken, no resume_ack.
- Reset mid-step: rst during STEP with counter=2 -> RUN, cpu_stall=0, halt_cause=0, dpc=RESET_PC. With HALT_ON_RESET=1 -> halted=1 immediately after reset.
